// File: rtl/axi_time_pkg.sv
// Shared definitions for the axi_time timekeeping core.
//   CH_RX / CH_TX : channel indices into every per-channel vector
//   NUM_CH        : number of capture/trigger channels
//   time_t        : native 64-bit time value
//   trig_state_t  : per-channel trigger FSM states
package axi_time_pkg;

  localparam int unsigned CH_RX  = 0;
  localparam int unsigned CH_TX  = 1;
  localparam int unsigned NUM_CH = 2;

  typedef logic [63:0] time_t;

  typedef enum logic {
    TRIG_IDLE,
    TRIG_ARMED
  } trig_state_t;

endpackage

// File: rtl/axi_time_channel.sv
// One capture/trigger channel of the axi_time core.
//   clk, rst      : core clock, async active-high reset
//   time_cnt      : current time from the counter
//   capt_in       : capture event level; a rising edge timestamps time_cnt
//   capt_clr      : strobe clearing capt_valid / capt_overrun
//   capt_value    : last captured timestamp
//   capt_valid    : sticky, a capture is held
//   capt_overrun  : sticky, a capture landed while one was already held
//   trig_arm      : strobe loading trig_value as the new target
//   trig_value    : trigger target
//   trig_armed    : trigger pending
//   trig_late     : sticky, last arm was rejected (target already passed)
//   trig_out      : registered one-cycle trigger pulse
module axi_time_channel
  import axi_time_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] time_cnt,
  input  logic         capt_in,
  input  logic         capt_clr,
  output logic [W-1:0] capt_value,
  output logic         capt_valid,
  output logic         capt_overrun,
  input  logic         trig_arm,
  input  logic [W-1:0] trig_value,
  output logic         trig_armed,
  output logic         trig_late,
  output logic         trig_out
);

  // Capture path
  logic         r_capt_in_q;
  logic         r_capt_rdy;
  logic         w_rise;
  logic [W-1:0] r_capt_value, w_capt_value_nxt;
  logic         r_capt_valid, w_capt_valid_nxt;
  logic         r_capt_overrun, w_capt_overrun_nxt;

  // Trigger path
  trig_state_t  r_state, w_state_nxt;
  logic [W-1:0] r_target, w_target_nxt;
  logic         r_late, w_late_nxt;
  logic         r_trig_out, w_trig_out_nxt;

  always_comb begin
    // r_capt_rdy masks the first sample after reset so a level that is
    // already high when reset releases is not mistaken for an edge.
    w_rise           = capt_in & ~r_capt_in_q & r_capt_rdy;
    w_capt_value_nxt = r_capt_value;
    if (w_rise) begin
      w_capt_value_nxt = time_cnt;
    end
    w_capt_valid_nxt = w_rise | (r_capt_valid & ~capt_clr);
    // A capture coinciding with a clear counts as a fresh capture, not overrun.
    if (w_rise) begin
      w_capt_overrun_nxt = r_capt_valid & ~capt_clr;
    end else begin
      w_capt_overrun_nxt = r_capt_overrun & ~capt_clr;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_target_nxt   = r_target;
    w_late_nxt     = r_late;
    w_trig_out_nxt = 1'b0;
    // Arm takes precedence over a fire of the previous target.
    if (trig_arm) begin
      w_target_nxt = trig_value;
      if (trig_value > time_cnt) begin
        w_state_nxt = TRIG_ARMED;
        w_late_nxt  = 1'b0;
      end else begin
        w_state_nxt = TRIG_IDLE;
        w_late_nxt  = 1'b1;
      end
    end else begin
      unique case (r_state)
        TRIG_ARMED: begin
          if (time_cnt >= r_target) begin
            w_state_nxt    = TRIG_IDLE;
            w_trig_out_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_capt_in_q    <= 1'b0;
      r_capt_rdy     <= 1'b0;
      r_capt_value   <= '0;
      r_capt_valid   <= 1'b0;
      r_capt_overrun <= 1'b0;
      r_state        <= TRIG_IDLE;
      r_target       <= '0;
      r_late         <= 1'b0;
      r_trig_out     <= 1'b0;
    end else begin
      r_capt_in_q    <= capt_in;
      r_capt_rdy     <= 1'b1;
      r_capt_value   <= w_capt_value_nxt;
      r_capt_valid   <= w_capt_valid_nxt;
      r_capt_overrun <= w_capt_overrun_nxt;
      r_state        <= w_state_nxt;
      r_target       <= w_target_nxt;
      r_late         <= w_late_nxt;
      r_trig_out     <= w_trig_out_nxt;
    end
  end

  assign capt_value   = r_capt_value;
  assign capt_valid   = r_capt_valid;
  assign capt_overrun = r_capt_overrun;
  assign trig_armed   = (r_state == TRIG_ARMED);
  assign trig_late    = r_late;
  assign trig_out     = r_trig_out;

endmodule

// File: rtl/axi_time_counter.sv
// Timekeeping core downstream of the axi_time register map: free-running
// counter plus per-channel capture/trigger units (channel 0 = RX, 1 = TX).
//   clk, rst      : core clock, async active-high reset
//   ctrl_enable   : counter increment enable (level)
//   ctrl_ovwr     : strobe loading ovwr_value into the counter (priority)
//   ovwr_value    : counter load value
//   time_cnt      : current time
//   capt_*        : per-channel capture inputs/status, values flattened ch0 low
//   trig_*        : per-channel trigger inputs/status, values flattened ch0 low
module axi_time_counter #(
  parameter int unsigned W      = 64,
  parameter int unsigned NUM_CH = axi_time_pkg::NUM_CH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ctrl_enable,
  input  logic                ctrl_ovwr,
  input  logic [W-1:0]        ovwr_value,
  output logic [W-1:0]        time_cnt,
  input  logic [NUM_CH-1:0]   capt_in,
  input  logic [NUM_CH-1:0]   capt_clr,
  output logic [NUM_CH*W-1:0] capt_value,
  output logic [NUM_CH-1:0]   capt_valid,
  output logic [NUM_CH-1:0]   capt_overrun,
  input  logic [NUM_CH-1:0]   trig_arm,
  input  logic [NUM_CH*W-1:0] trig_value,
  output logic [NUM_CH-1:0]   trig_armed,
  output logic [NUM_CH-1:0]   trig_late,
  output logic [NUM_CH-1:0]   trig_out
);

  logic [W-1:0] r_time_cnt, w_time_cnt_nxt;

  always_comb begin
    w_time_cnt_nxt = r_time_cnt;
    if (ctrl_ovwr) begin
      w_time_cnt_nxt = ovwr_value;
    end else if (ctrl_enable) begin
      w_time_cnt_nxt = r_time_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_time_cnt <= '0;
    end else begin
      r_time_cnt <= w_time_cnt_nxt;
    end
  end

  assign time_cnt = r_time_cnt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    axi_time_channel #(
      .W(W)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .time_cnt     (r_time_cnt),
      .capt_in      (capt_in[g]),
      .capt_clr     (capt_clr[g]),
      .capt_value   (capt_value[g*W +: W]),
      .capt_valid   (capt_valid[g]),
      .capt_overrun (capt_overrun[g]),
      .trig_arm     (trig_arm[g]),
      .trig_value   (trig_value[g*W +: W]),
      .trig_armed   (trig_armed[g]),
      .trig_late    (trig_late[g]),
      .trig_out     (trig_out[g])
    );
  end

endmodule

// File: tb/tb_axi_time_counter.sv
module tb_axi_time_counter;

  localparam int W      = 64;
  localparam int NUM_CH = 2;

  localparam int S_TIME = 0, S_CV_RX = 1, S_CV_TX = 2, S_VALID = 3;
  localparam int S_OVR = 4, S_ARMED = 5, S_LATE = 6, S_TOUT = 7;

  logic                clk = 1'b0;
  logic                rst;
  logic                ctrl_enable;
  logic                ctrl_ovwr;
  logic [W-1:0]        ovwr_value;
  logic [W-1:0]        time_cnt;
  logic [NUM_CH-1:0]   capt_in;
  logic [NUM_CH-1:0]   capt_clr;
  logic [NUM_CH*W-1:0] capt_value;
  logic [NUM_CH-1:0]   capt_valid;
  logic [NUM_CH-1:0]   capt_overrun;
  logic [NUM_CH-1:0]   trig_arm;
  logic [NUM_CH*W-1:0] trig_value;
  logic [NUM_CH-1:0]   trig_armed;
  logic [NUM_CH-1:0]   trig_late;
  logic [NUM_CH-1:0]   trig_out;

  always #5 clk = ~clk;

  axi_time_counter #(
    .W      (W),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl_enable  (ctrl_enable),
    .ctrl_ovwr    (ctrl_ovwr),
    .ovwr_value   (ovwr_value),
    .time_cnt     (time_cnt),
    .capt_in      (capt_in),
    .capt_clr     (capt_clr),
    .capt_value   (capt_value),
    .capt_valid   (capt_valid),
    .capt_overrun (capt_overrun),
    .trig_arm     (trig_arm),
    .trig_value   (trig_value),
    .trig_armed   (trig_armed),
    .trig_late    (trig_late),
    .trig_out     (trig_out)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] val;
  } exp_t;

  typedef struct {
    logic        en;
    logic        ovwr;
    logic [63:0] val;
    logic [63:0] exp_time;
  } cnt_vec_t;

  exp_t     sb[$];
  cnt_vec_t vecs[16];
  int       n_cmp = 0;
  int       n_err = 0;

  function automatic logic [63:0] get_out(input int sel);
    case (sel)
      S_TIME:  return time_cnt;
      S_CV_RX: return capt_value[63:0];
      S_CV_TX: return capt_value[127:64];
      S_VALID: return {62'd0, capt_valid};
      S_OVR:   return {62'd0, capt_overrun};
      S_ARMED: return {62'd0, trig_armed};
      S_LATE:  return {62'd0, trig_late};
      S_TOUT:  return {62'd0, trig_out};
      default: return '1;
    endcase
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input string nm, input int sel, input logic [63:0] v);
    exp_t e;
    e.name = nm;
    e.sel  = sel;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmp(e.name, get_out(e.sel), e.val);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ovwr_to(input logic [63:0] v);
    ctrl_ovwr  = 1'b1;
    ovwr_value = v;
    step();
    ctrl_ovwr  = 1'b0;
  endtask

  task automatic arm(input int ch, input logic [63:0] v);
    trig_value[ch*W +: W] = v;
    trig_arm              = 2'b00;
    trig_arm[ch]          = 1'b1;
    step();
    trig_arm              = 2'b00;
  endtask

  task automatic push_all_zero(input string nm);
    for (int s = 0; s <= S_TOUT; s++) push_exp(nm, s, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int fired;

    rst         = 1'b1;
    ctrl_enable = 1'b0;
    ctrl_ovwr   = 1'b0;
    ovwr_value  = '0;
    capt_in     = '0;
    capt_clr    = '0;
    trig_arm    = '0;
    trig_value  = '0;

    // Counter vectors: {enable, ovwr, ovwr_value, expected time_cnt}
    for (int i = 0; i < 10; i++) vecs[i] = '{1'b1, 1'b0, 64'd0, 64'(i + 1)};
    vecs[10] = '{1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[11] = '{1'b1, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[12] = '{1'b1, 1'b0, 64'd0, 64'd0};
    vecs[13] = '{1'b1, 1'b0, 64'd0, 64'd1};
    vecs[14] = '{1'b0, 1'b0, 64'd0, 64'd1};
    vecs[15] = '{1'b0, 1'b1, 64'd500, 64'd500};

    step(2);
    push_all_zero("reset");
    check();
    rst = 1'b0;

    // 1. Counter: increment, overwrite, wrap, hold
    foreach (vecs[i]) begin
      ctrl_enable = vecs[i].en;
      ctrl_ovwr   = vecs[i].ovwr;
      ovwr_value  = vecs[i].val;
      step();
      push_exp("cnt_vec", S_TIME, vecs[i].exp_time);
      check();
    end
    ctrl_ovwr   = 1'b0;
    ctrl_enable = 1'b0;

    // 2. Capture on RX (counter frozen at 500)
    capt_in[0] = 1'b1;
    step();
    push_exp("capt1_value", S_CV_RX, 64'd500);
    push_exp("capt1_valid", S_VALID, 64'd1);
    push_exp("capt1_ovr", S_OVR, 64'd0);
    push_exp("capt1_tx_untouched", S_CV_TX, 64'd0);
    check();
    capt_in[0] = 1'b0;
    step();
    ovwr_to(64'd520);
    capt_in[0] = 1'b1;
    step();
    capt_in[0] = 1'b0;
    push_exp("capt2_value", S_CV_RX, 64'd520);
    push_exp("capt2_valid", S_VALID, 64'd1);
    push_exp("capt2_ovr", S_OVR, 64'd1);
    check();
    capt_clr[0] = 1'b1;
    step();
    capt_clr[0] = 1'b0;
    push_exp("clr_value", S_CV_RX, 64'd520);
    push_exp("clr_valid", S_VALID, 64'd0);
    push_exp("clr_ovr", S_OVR, 64'd0);
    check();
    ovwr_to(64'd530);
    capt_in[0]  = 1'b1;
    capt_clr[0] = 1'b1;
    step();
    capt_in[0]  = 1'b0;
    capt_clr[0] = 1'b0;
    push_exp("clrcapt_value", S_CV_RX, 64'd530);
    push_exp("clrcapt_valid", S_VALID, 64'd1);
    push_exp("clrcapt_ovr", S_OVR, 64'd0);
    check();

    // 3. TX trigger fires in the cycle after time_cnt == target
    ovwr_to(64'd900);
    arm(1, 64'd1000);
    push_exp("tx_arm_armed", S_ARMED, 64'b10);
    push_exp("tx_arm_late", S_LATE, 64'd0);
    check();
    ctrl_enable = 1'b1;
    ovwr_to(64'd998);
    push_exp("tx_time998", S_TIME, 64'd998);
    check();
    step();
    push_exp("tx_out_at999", S_TOUT, 64'd0);
    check();
    step();
    push_exp("tx_out_at1000", S_TOUT, 64'd0);
    push_exp("tx_armed_at1000", S_ARMED, 64'b10);
    check();
    step();
    push_exp("tx_fire", S_TOUT, 64'b10);
    push_exp("tx_fire_armed", S_ARMED, 64'd0);
    push_exp("tx_fire_time", S_TIME, 64'd1001);
    check();
    step();
    push_exp("tx_fire_one_cycle", S_TOUT, 64'd0);
    check();
    ctrl_enable = 1'b0;

    // 4. Late arm on RX, then re-arm
    ovwr_to(64'd50);
    arm(0, 64'd50);
    push_exp("late_flag", S_LATE, 64'b01);
    push_exp("late_armed", S_ARMED, 64'd0);
    push_exp("late_out", S_TOUT, 64'd0);
    check();
    step();
    push_exp("late_no_pulse", S_TOUT, 64'd0);
    check();
    arm(0, 64'd80);
    push_exp("rearm_late", S_LATE, 64'd0);
    push_exp("rearm_armed", S_ARMED, 64'b01);
    check();
    ctrl_enable = 1'b1;
    step(30);
    push_exp("rearm_time80", S_TIME, 64'd80);
    push_exp("rearm_no_early", S_TOUT, 64'd0);
    check();
    step();
    push_exp("rearm_fire", S_TOUT, 64'b01);
    push_exp("rearm_fire_time", S_TIME, 64'd81);
    check();
    ctrl_enable = 1'b0;

    // 5a. Forward overwrite past the target fires
    ovwr_to(64'd1500);
    arm(0, 64'd2000);
    push_exp("fwd_armed", S_ARMED, 64'b01);
    check();
    ovwr_to(64'd5000);
    push_exp("fwd_time", S_TIME, 64'd5000);
    push_exp("fwd_not_yet", S_TOUT, 64'd0);
    check();
    step();
    push_exp("fwd_fire", S_TOUT, 64'b01);
    push_exp("fwd_disarmed", S_ARMED, 64'd0);
    check();

    // 5b. Backward overwrite keeps ARMED; frozen counter does not fire
    ovwr_to(64'd1500);
    arm(0, 64'd2000);
    ovwr_to(64'd10);
    push_exp("bwd_armed", S_ARMED, 64'b01);
    push_exp("bwd_out", S_TOUT, 64'd0);
    push_exp("bwd_time", S_TIME, 64'd10);
    check();
    step();
    push_exp("bwd_frozen_armed", S_ARMED, 64'b01);
    push_exp("bwd_frozen_time", S_TIME, 64'd10);
    check();
    ctrl_enable = 1'b1;
    fired = -1;
    for (int k = 1; k <= 3000; k++) begin
      step();
      if (trig_out[0]) begin
        fired = k;
        break;
      end
    end
    cmp("bwd_fire_cycle", 64'(fired), 64'd1991);
    push_exp("bwd_fire_time", S_TIME, 64'd2001);
    push_exp("bwd_fire_armed", S_ARMED, 64'd0);
    check();
    ctrl_enable = 1'b0;

    // Arm and fire condition in the same cycle: the arm wins
    ovwr_to(64'd100);
    arm(1, 64'd200);
    ovwr_to(64'd300);
    arm(1, 64'd400);
    push_exp("collide_armed", S_ARMED, 64'b10);
    push_exp("collide_out", S_TOUT, 64'd0);
    push_exp("collide_late", S_LATE, 64'd0);
    check();
    step();
    push_exp("collide_still_armed", S_ARMED, 64'b10);
    push_exp("collide_no_pulse", S_TOUT, 64'd0);
    check();

    // 6. Async reset one count before the target; capt_in high across release
    ovwr_to(64'd399);
    ctrl_enable = 1'b1;
    capt_in     = 2'b11;
    #2;
    rst = 1'b1;
    #1;
    push_all_zero("async_rst");
    check();
    ctrl_enable = 1'b0;
    step(2);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      push_exp("post_rst_out", S_TOUT, 64'd0);
      push_exp("post_rst_armed", S_ARMED, 64'd0);
      push_exp("post_rst_valid", S_VALID, 64'd0);
      push_exp("post_rst_time", S_TIME, 64'd0);
      check();
    end
    capt_in = 2'b00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_time_counter.md
Name: axi_time_counter

Overview:
- Timekeeping core that sits directly downstream of the axi_time register map.
- Consumes the CONTROL, CNT_OVWR, RX/TX_TRIG values and strobes decoded by the register block.
- Produces the free-running time counter, the RX/TX capture timestamps and the RX/TX trigger pulses that are read back through STATUS and the *_CAPT registers.
- Channel 0 = RX, channel 1 = TX. All channel vectors are indexed this way; flattened value buses place channel 0 in the low W bits.

Parameters:
- W, 64: width of time counter, overwrite, capture and trigger values.
- NUM_CH, 2: number of capture/trigger channels; fixed at 2 (RX, TX).

Ports:
- clk  in  1  core clock; all logic is synchronous to it.
- rst  in  1  asynchronous, active-high reset.
- ctrl_enable  in  1  counter increment enable (level).
- ctrl_ovwr  in  1  one-cycle strobe: load ovwr_value into the counter.
- ovwr_value  in  W  counter load value ({CNT_OVWR_HIGH, CNT_OVWR_LOW}).
- time_cnt  out  W  current time.
- capt_in  in  NUM_CH  per-channel capture event (level; rising edge captures).
- capt_clr  in  NUM_CH  per-channel strobe: clear capt_valid and capt_overrun.
- capt_value  out  NUM_CH*W  captured timestamps.
- capt_valid  out  NUM_CH  sticky: capture held.
- capt_overrun  out  NUM_CH  sticky: a capture occurred while capt_valid was already 1.
- trig_arm  in  NUM_CH  per-channel strobe: arm with trig_value.
- trig_value  in  NUM_CH*W  trigger targets ({TRIG_HIGH, TRIG_LOW}).
- trig_armed  out  NUM_CH  trigger pending.
- trig_late  out  NUM_CH  sticky: arm was rejected because its target was already passed.
- trig_out  out  NUM_CH  one-cycle trigger pulse.

Behaviour:
- Reset: every output is 0, including time_cnt, all capture/trigger state and the internal capt_in edge register.
- Counter:
  - ctrl_ovwr has priority: time_cnt <= ovwr_value, regardless of ctrl_enable.
  - Else, if ctrl_enable: time_cnt <= time_cnt + 1, unsigned, wrapping from 2^W-1 to 0.
  - Else: time_cnt holds.
- Capture, per channel:
  - capt_in is registered once; a rise is capt_in & ~capt_in_q.
  - On a rise, capt_value <= time_cnt as seen in that same cycle, and capt_valid <= 1.
  - If capt_valid was already 1, capt_value is overwritten and capt_overrun <= 1.
  - capt_clr alone clears capt_valid and capt_overrun; capt_value holds.
  - capt_clr and a rise in the same cycle: the capture wins. Result is capt_valid=1, capt_overrun=0, capt_value updated.
  - capt_in already high when reset releases produces no capture.
- Trigger, per channel. States IDLE, ARMED, plus the sticky late flag.
  - trig_arm in any state: latch trig_value into the internal target and clear trig_late.
  - If target > time_cnt (unsigned, same cycle): enter ARMED (trig_armed=1).
  - Otherwise: stay/go IDLE, trig_late <= 1, no pulse.
  - Re-arming while ARMED replaces the target and re-evaluates the late check.
  - In ARMED, a cycle with time_cnt >= target drives trig_out=1 in the next cycle for exactly one cycle and returns to IDLE.
  - Example: target 100, time_cnt=100 in cycle N gives trig_out in cycle N+1.
  - An overwrite that jumps the counter forward past the target fires on the first cycle time_cnt >= target.
  - A backward overwrite keeps the trigger ARMED.
  - ctrl_enable=0 freezes time_cnt; ARMED then fires only via an overwrite.
  - trig_arm and the fire condition in the same cycle: the arm wins (new target evaluated); the old target does not fire.
- No combinational path from any input to any output.
- Reset asserted mid-operation returns everything to the reset values immediately, with no trigger pulse.

Decomposition:
- axi_time_pkg gains:
  - CH_RX=0, CH_TX=1, NUM_CH=2.
  - typedef logic [63:0] time_t.
  - typedef enum {TRIG_IDLE, TRIG_ARMED} trig_state_t.
- Sub-module axi_time_channel: the capture and trigger logic for one channel, taking time_cnt as an input. It is instantiated NUM_CH times via generate.
- axi_time_counter itself holds only the counter and the instances.

Test Plan:
1. Reset, enable=1 for 10 cycles -> time_cnt=10; then ovwr strobe with 0xFFFF_FFFF_FFFF_FFFE, enable=1 -> next cycles read ...FFFE, ...FFFF, 0 (wrap).
2. time_cnt=500, rise on capt_in[RX] -> capt_value[RX]=500, capt_valid[RX]=1. Second rise at 520 -> value 520, capt_overrun=1. capt_clr -> valid=0, overrun=0, value stays 520. capt_clr simultaneous with a rise at 530 -> valid=1, overrun=0, value 530.
3. Arm TX with target 1000 at time_cnt=900 -> trig_armed[TX]=1. trig_out[TX] is high only in the cycle after time_cnt=1000; trig_armed then drops.
4. Arm RX with target 50 at time_cnt=50 -> trig_late[RX]=1, trig_armed=0, no trig_out. Re-arm with target 80 -> trig_late clears and the trigger fires after time_cnt=80.
5. Armed target 2000, time_cnt=1500, ovwr to 5000 -> trig_out one cycle later. Separately, armed target 2000 with ovwr to 10 -> stays ARMED and fires after time_cnt reaches 2000.
6. Assert rst while ARMED with time_cnt one below target -> all outputs 0, no trig_out pulse after release.
